// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-add integer multiplier.
// Retires BITS_PER_CYCLE multiplier bits per clock. Signed operands are
// turned into magnitudes on acceptance and the sign is restored on the final
// sum. Uses valid/ready handshakes on both sides and holds the result until
// the consumer takes it.
module iterative_multiplier #(
    parameter int DATA_WIDTH     = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [DATA_WIDTH-1:0]     InputA,
    input  logic [DATA_WIDTH-1:0]     InputB,
    input  logic                      Sign,
    input  logic                      InValid,
    output logic                      InReady,
    output logic [2*DATA_WIDTH-1:0]   Product,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic                      Busy
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int N_IT  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(N_IT + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(N_IT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] a_q,         a_d;
    logic [PW-1:0]         b_q,         b_d;
    logic [PW-1:0]         acc_q,       acc_d;
    logic                  neg_q,       neg_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [PW-1:0]         product_q,   product_d;
    logic                  out_valid_q, out_valid_d;

    logic                  in_ready_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] mag_a_s;
    logic [DATA_WIDTH-1:0] mag_b_s;
    logic [PW-1:0]         part_s;
    logic [PW-1:0]         sum_s;

    // Ready in IDLE, or in DONE when the result is being consumed this cycle.
    always_comb begin
        in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && OutReady);
        accept_s   = InValid && in_ready_s;
    end

    // Operand magnitudes; the most-negative value maps onto 2^(DW-1) unchanged.
    always_comb begin
        if (Sign && InputA[DATA_WIDTH-1]) begin
            mag_a_s = {DATA_WIDTH{1'b0}} - InputA;
        end else begin
            mag_a_s = InputA;
        end
        if (Sign && InputB[DATA_WIDTH-1]) begin
            mag_b_s = {DATA_WIDTH{1'b0}} - InputB;
        end else begin
            mag_b_s = InputB;
        end
    end

    // Partial product of the low multiplier digit and the running sum.
    always_comb begin
        part_s = {{(PW-BITS_PER_CYCLE){1'b0}}, a_q[BITS_PER_CYCLE-1:0]} * b_q;
        sum_s  = acc_q + part_s;
    end

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d = sum_s;
                a_d   = a_q >> BITS_PER_CYCLE;
                b_d   = b_q << BITS_PER_CYCLE;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (neg_q) begin
                        product_d = {PW{1'b0}} - sum_s;
                    end else begin
                        product_d = sum_s;
                    end
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    if (InValid) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Operand load overrides the iteration update on an accepted handshake.
        if (accept_s) begin
            a_d   = mag_a_s;
            b_d   = {{DATA_WIDTH{1'b0}}, mag_b_s};
            acc_d = {PW{1'b0}};
            neg_d = Sign & (InputA[DATA_WIDTH-1] ^ InputB[DATA_WIDTH-1]);
            cnt_d = CNT_LOAD;
        end else begin
            neg_d = neg_d;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= {DATA_WIDTH{1'b0}};
            b_q         <= {PW{1'b0}};
            acc_q       <= {PW{1'b0}};
            neg_q       <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            product_q   <= {PW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output drive; Busy decodes the registered state directly.
    always_comb begin
        InReady  = in_ready_s;
        Product  = product_q;
        OutValid = out_valid_q;
        Busy     = (state_q == S_BUSY);
    end

endmodule
